cla_pipe_adder: RTL
===================

Name: cla_pipe_adder

Overview:
Parametrised, pipelined carry-lookahead adder/subtractor. It supersedes the fixed 4-bit combinational CLA in the datapath. The operand is split into BLOCK-bit lookahead groups, and one group is resolved per pipeline stage, with operand skew and result de-skew registers. A valid/ready handshake on both sides lets it sit between streaming producers and consumers with back-pressure.

Parameters:
WIDTH, 16, operand/sum width in bits; must be a multiple of BLOCK and >= BLOCK
BLOCK, 4, bits per carry-lookahead group (one group per pipeline stage)
NSTAGES, WIDTH/BLOCK, derived localparam: pipeline depth; not overridable

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand beat valid
in_ready  out  1  block can accept a beat this cycle
a  in  WIDTH  operand A (unsigned or two's complement)
b  in  WIDTH  operand B
cin  in  1  carry in; ignored when sub=1
sub  in  1  0: s=a+b+cin; 1: s=a-b (a+~b+1)
out_valid  out  1  result beat valid
out_ready  in  1  consumer accepts result this cycle
s  out  WIDTH  sum/difference
cout  out  1  carry out of MSB (sub: 1 = no borrow)
ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB

Behaviour:
- Reset (rst_n low, asynchronous): every stage valid bit is cleared, and out_valid=0, s=0, cout=0, ovf=0. in_ready reads 1 while out_valid=0. Data registers may also be cleared.
- Reset mid-operation discards all in-flight beats. No result from before reset ever appears after rst_n deasserts.
- Stage k (0..NSTAGES-1) computes group k, bits [k*BLOCK +: BLOCK].
  - It uses per-bit generate g=a&b' and propagate p=a^b', where b' = sub ? ~b : b.
  - Group carries are full lookahead within the group, not ripple.
  - Carry-in to stage 0 = sub ? 1 : cin. Carry-in to stage k>0 = registered carry-out of stage k-1.
- Operand groups above stage k are carried forward in skew registers. Finished sum groups are carried forward in de-skew registers, so the final stage presents the aligned WIDTH-bit result.
- The last stage registers cout and ovf.
- Latency: a beat accepted on edge t appears with out_valid=1 after edge t+NSTAGES, i.e. NSTAGES cycles.
- Throughput: one beat per cycle while out_ready=1.
- Flow control uses a global stall: adv = out_ready | ~out_valid. When adv=1 all stages shift by one; when adv=0 all stages hold. in_ready = adv (combinational).
- A beat transfers when in_valid & in_ready, or when out_valid & out_ready.
- When in_valid=0 and adv=1, a bubble (valid=0) enters stage 0. Bubbles are not collapsed except at the output, via ~out_valid in adv.
- While out_valid=1 and out_ready=0, s, cout and ovf are held stable and the pipeline holds.
- Simultaneous output transfer and input accept in the same cycle is legal; order is preserved, FIFO.
- Arithmetic is modulo 2^WIDTH. ovf is meaningful for both add and sub.
- No combinational path from a/b/cin/sub to any output. in_ready depends only on out_ready and internal state.
- Elaboration error if WIDTH % BLOCK != 0.

Test Plan:
(All with WIDTH=16, BLOCK=4, latency 4.)
- Basic add: a=0x0001, b=0x0001, cin=0, sub=0, out_ready=1 -> 4 cycles later s=0x0002, cout=0, ovf=0, out_valid high for exactly one cycle.
- Full carry chain across all stages: a=0xFFFF, b=0x0000, cin=1 -> s=0x0000, cout=1, ovf=0. Also a=0x7FFF, b=0x0001, cin=0 -> s=0x8000, cout=0, ovf=1.
- Subtract: a=0x0003, b=0x0005, sub=1, cin=1 (ignored) -> s=0xFFFE, cout=0, ovf=0. Also a=0x8000, b=0x0001, sub=1 -> s=0x7FFF, cout=1, ovf=1.
- Streaming plus back-pressure:
  - Issue 6 back-to-back beats (a=i, b=i, i=1..6).
  - Drop out_ready for 3 cycles when the first result appears.
  - Required: in_ready=0 during the stall, first result held stable, results 2,4,6,8,10,12 in order with none lost or duplicated.
- Reset mid-flight: accept 2 beats, assert rst_n low asynchronously between edges -> out_valid, s, cout and ovf go to 0 immediately. After release, no stale results appear, and a new beat 0x1234+0x1111 returns 0x2345.
- Random self-check: 10k random a/b/cin/sub with random in_valid/out_ready, checked against a reference model -> zero mismatches.

Source files
------------

// File: rtl/cla_pipe_adder_if.sv
// Operand/result streaming bundle for cla_pipe_adder: valid/ready on both the
// operand side and the result side.
interface cla_pipe_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, s, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, s, cout, ovf
  );
endinterface

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor: one BLOCK-bit lookahead group per
// stage behind an input register, globally stalled by result back-pressure.
module cla_pipe_adder #(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  cla_pipe_adder_if.slave bus
);
  localparam int NSTAGES = WIDTH / BLOCK;

  if (((WIDTH % BLOCK) != 0) || (WIDTH < BLOCK)) begin : g_bad_cfg
    $error("cla_pipe_adder: WIDTH must be a non-zero multiple of BLOCK");
  end

  // Returns {carry out, carry into group MSB, group sum}; every carry is a flat
  // sum of products over g/p/ci so no carry waits on its neighbour.
  function automatic logic [BLOCK+1:0] cla_group(input logic [BLOCK-1:0] ga,
                                                 input logic [BLOCK-1:0] gb,
                                                 input logic             ci);
    logic [BLOCK-1:0] g;
    logic [BLOCK-1:0] p;
    logic [BLOCK:0]   c;
    logic             acc;
    logic             pr;
    g    = ga & gb;
    p    = ga ^ gb;
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < BLOCK; i++) begin
      acc = g[i];
      pr  = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        acc = acc | (pr & g[j]);
        pr  = pr & p[j];
      end
      c[i+1] = acc | (pr & ci);
    end
    return {c[BLOCK], c[BLOCK-1], p ^ c[BLOCK-1:0]};
  endfunction

  logic             adv_s;
  logic             iv_r;
  logic             ic_r;
  logic [WIDTH-1:0] ia_r;
  logic [WIDTH-1:0] ib_r;
  logic             ovf_r;

  assign adv_s = bus.out_ready | ~stg[NSTAGES-1].vld_r;

  // Input register; subtraction is folded into b and the stage-0 carry here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iv_r <= 1'b0;
      ia_r <= '0;
      ib_r <= '0;
      ic_r <= 1'b0;
    end else if (adv_s) begin
      iv_r <= bus.in_valid;
      ia_r <= bus.a;
      ib_r <= bus.sub ? ~bus.b : bus.b;
      ic_r <= bus.sub ? 1'b1 : bus.cin;
    end
  end

  for (genvar k = 0; k < NSTAGES; k++) begin : stg
    logic             vld_s;
    logic             ci_s;
    logic [WIDTH-1:0] a_s;
    logic [WIDTH-1:0] b_s;
    logic [WIDTH-1:0] sum_s;
    logic [WIDTH-1:0] sum_nxt_s;
    logic [BLOCK+1:0] res_s;
    logic             vld_r;
    logic             c_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] sum_r;

    if (k == 0) begin : g_src
      assign vld_s = iv_r;
      assign a_s   = ia_r;
      assign b_s   = ib_r;
      assign ci_s  = ic_r;
      assign sum_s = '0;
    end else begin : g_src
      assign vld_s = stg[k-1].vld_r;
      assign a_s   = stg[k-1].a_r;
      assign b_s   = stg[k-1].b_r;
      assign ci_s  = stg[k-1].c_r;
      assign sum_s = stg[k-1].sum_r;
    end

    assign res_s = cla_group(a_s[k*BLOCK +: BLOCK], b_s[k*BLOCK +: BLOCK], ci_s);

    // Merge this stage's group into the partially de-skewed sum.
    always_comb begin
      sum_nxt_s                     = sum_s;
      sum_nxt_s[k*BLOCK +: BLOCK]   = res_s[BLOCK-1:0];
    end

    // Stage register: operand skew, group carry, and finished sum groups.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_r <= 1'b0;
        c_r   <= 1'b0;
        a_r   <= '0;
        b_r   <= '0;
        sum_r <= '0;
      end else if (adv_s) begin
        vld_r <= vld_s;
        c_r   <= res_s[BLOCK+1];
        a_r   <= a_s;
        b_r   <= b_s;
        sum_r <= sum_nxt_s;
      end
    end

    if (k == NSTAGES - 1) begin : g_flags
      logic unused_s;
      assign unused_s = ^{a_r, b_r};

      // Signed overflow from the carries into and out of the MSB.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_r <= 1'b0;
        end else if (adv_s) begin
          ovf_r <= res_s[BLOCK+1] ^ res_s[BLOCK];
        end
      end
    end else begin : g_flags
      logic unused_s;
      assign unused_s = res_s[BLOCK];
    end
  end

  assign bus.in_ready  = adv_s;
  assign bus.out_valid = stg[NSTAGES-1].vld_r;
  assign bus.s         = stg[NSTAGES-1].sum_r;
  assign bus.cout      = stg[NSTAGES-1].c_r;
  assign bus.ovf       = ovf_r;
endmodule
